// File: rtl/dmem_responder.sv
// Multi-cycle, single-outstanding data memory with valid/ready request and response channels.
// A request waits LATENCY cycles, commits on entry to RESP, and its response is held until accepted.
module dmem_responder #(
    parameter int unsigned ADDR_WIDTH = 13,
    parameter int unsigned LATENCY    = 2,
    parameter string       INIT_FILE  = "DataMemory.txt"
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;
    localparam int unsigned LatM1 = (LATENCY == 0) ? 0 : LATENCY - 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        write_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    logic [31:0] mem [Depth];

    logic                  commit;
    logic                  op_write;
    logic [31:0]           op_addr;
    logic [31:0]           op_wdata;
    logic [3:0]            op_wstrb;
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] op_idx;

    // With zero latency the commit happens on the accepting edge, so use the live request.
    always_comb begin
        op_write = write_q;
        op_addr  = addr_q;
        op_wdata = wdata_q;
        op_wstrb = wstrb_q;
        if (state_q == StIdle) begin
            op_write = req_write;
            op_addr  = req_addr;
            op_wdata = req_wdata;
            op_wstrb = req_wstrb;
        end
    end

    assign in_range = ((op_addr >> ADDR_WIDTH) == 32'd0);
    assign op_idx   = op_addr[ADDR_WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        commit  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (LATENCY == 0) begin
                        state_d = StResp;
                        commit  = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = LatM1[3:0];
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
        if (commit) begin
            err_d   = !in_range;
            rdata_d = (in_range && !op_write) ? mem[op_idx] : 32'd0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (state_q == StIdle && req_valid) begin
                write_q <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
            end
        end
    end

    // Memory contents survive reset; only the commit edge writes, and reset blocks it.
    always_ff @(posedge clock) begin
        if (!reset && commit && in_range && op_write) begin
            for (int i = 0; i < 4; i++) begin
                if (op_wstrb[i]) begin
                    mem[op_idx][8*i +: 8] <= op_wdata[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LATENCY=2 instance (index 0) and LATENCY=0 instance (index 1),
// checked every cycle against a transaction-level model plus hand-computed literals.
module tb_dmem_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid [2];
    logic        req_write [2];
    logic        req_ready [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_wstrb [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    dmem_responder #(.ADDR_WIDTH(13), .LATENCY(2), .INIT_FILE("")) dut0 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wstrb(req_wstrb[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0])
    );

    dmem_responder #(.ADDR_WIDTH(13), .LATENCY(0), .INIT_FILE("")) dut1 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wstrb(req_wstrb[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit          m_live = 1'b0;
    int          edge_n = 0;
    bit          m_busy  [2];
    bit          m_resp  [2];
    int          m_due   [2];
    bit          m_write [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic [3:0]  m_wstrb [2];
    logic [31:0] m_rdata [2];
    bit          m_err   [2];
    bit          m_known [2];
    logic [31:0] m_mem [longint];

    task automatic m_commit(input int id);
        longint      key;
        logic [31:0] w;
        logic [31:0] mask;
        key = (longint'(id) << 32) | longint'(m_addr[id]);
        m_resp[id]  = 1'b1;
        m_rdata[id] = 32'd0;
        m_err[id]   = 1'b0;
        m_known[id] = 1'b1;
        if (m_addr[id] > 32'h1FFF) begin
            m_err[id] = 1'b1;
        end else if (m_write[id]) begin
            w    = m_mem.exists(key) ? m_mem[key] : 32'd0;
            mask = {{8{m_wstrb[id][3]}}, {8{m_wstrb[id][2]}},
                    {8{m_wstrb[id][1]}}, {8{m_wstrb[id][0]}}};
            m_mem[key] = (w & ~mask) | (m_wdata[id] & mask);
        end else if (m_mem.exists(key)) begin
            m_rdata[id] = m_mem[key];
        end else begin
            m_known[id] = 1'b0;
        end
    endtask

    always @(posedge clock) begin
        edge_n++;
        for (int id = 0; id < 2; id++) begin
            if (reset) begin
                m_live      = 1'b1;
                m_busy[id]  = 1'b0;
                m_resp[id]  = 1'b0;
                m_rdata[id] = 32'd0;
                m_err[id]   = 1'b0;
                m_known[id] = 1'b1;
            end else if (m_resp[id]) begin
                if (rsp_ready[id]) begin
                    m_resp[id]  = 1'b0;
                    m_busy[id]  = 1'b0;
                    m_rdata[id] = 32'd0;
                    m_err[id]   = 1'b0;
                    m_known[id] = 1'b1;
                end
            end else if (m_busy[id]) begin
                if (edge_n == m_due[id]) m_commit(id);
            end else if (req_valid[id]) begin
                m_busy[id]  = 1'b1;
                m_write[id] = req_write[id];
                m_addr[id]  = req_addr[id];
                m_wdata[id] = req_wdata[id];
                m_wstrb[id] = req_wstrb[id];
                if (id == 1) m_commit(id);
                else m_due[id] = edge_n + 2;
            end
        end
    end

    always @(negedge clock) begin
        if (m_live) begin
            for (int id = 0; id < 2; id++) begin
                chk($sformatf("req_ready%0d", id), 32'(req_ready[id]), 32'(!m_busy[id]));
                chk($sformatf("rsp_valid%0d", id), 32'(rsp_valid[id]), 32'(m_resp[id]));
                chk($sformatf("rsp_err%0d", id), 32'(rsp_err[id]), 32'(m_err[id]));
                if (m_known[id]) chk($sformatf("rsp_rdata%0d", id), rsp_rdata[id], m_rdata[id]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic txn(input int id, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb, input int hold,
                       output logic [31:0] rd, output logic er, output int lat);
        int n;
        @(negedge clock);
        req_valid[id] = 1'b1;
        req_write[id] = wr;
        req_addr[id]  = addr;
        req_wdata[id] = wdata;
        req_wstrb[id] = wstrb;
        n = 0;
        while (!req_ready[id] && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) chk("accept_timeout", 32'(n), 32'd0);
        @(negedge clock);
        req_valid[id] = 1'b0;
        lat = 1;
        while (!rsp_valid[id] && lat < 50) begin
            @(negedge clock);
            lat++;
        end
        if (lat >= 50) chk("rsp_timeout", 32'(lat), 32'd0);
        rd = rsp_rdata[id];
        er = rsp_err[id];
        repeat (hold) @(negedge clock);
        rsp_ready[id] = 1'b1;
        @(negedge clock);
        rsp_ready[id] = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          acc [2];
        int          nacc;
        int          c;
        bit          just;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_write[i] = 1'b0; req_addr[i] = 32'd0;
            req_wdata[i] = 32'd0; req_wstrb[i] = 4'd0; rsp_ready[i] = 1'b0;
        end
        repeat (2) @(negedge clock);
        chk("reset_ready", 32'(req_ready[0]), 32'd1);
        chk("reset_valid", 32'(rsp_valid[0]), 32'd0);
        reset = 1'b0;

        // 1: store then load, latency 2 -> response three cycles after acceptance
        txn(0, 1'b1, 32'd5, 32'hDEADBEEF, 4'hF, 0, rd, er, lat);
        chk("t1_store_rdata", rd, 32'd0);
        chk("t1_store_err", 32'(er), 32'd0);
        chk("t1_latency", 32'(lat), 32'd3);
        txn(0, 1'b0, 32'd5, 32'd0, 4'h0, 0, rd, er, lat);
        chk("t1_load", rd, 32'hDEADBEEF);

        // 2: byte strobes
        txn(0, 1'b1, 32'd7, 32'h11223344, 4'hF, 0, rd, er, lat);
        txn(0, 1'b1, 32'd7, 32'hAABBCCDD, 4'b0101, 0, rd, er, lat);
        txn(0, 1'b0, 32'd7, 32'd0, 4'h0, 0, rd, er, lat);
        chk("t2_strobe_load", rd, 32'h11BB33DD);
        txn(0, 1'b1, 32'd7, 32'hFFFFFFFF, 4'b0000, 0, rd, er, lat);
        txn(0, 1'b0, 32'd7, 32'd0, 4'h0, 0, rd, er, lat);
        chk("t2_zero_strobe", rd, 32'h11BB33DD);

        // 3: backpressure held for four cycles
        txn(0, 1'b0, 32'd5, 32'd0, 4'h0, 4, rd, er, lat);
        chk("t3_load", rd, 32'hDEADBEEF);
        chk("t3_ready_after", 32'(req_ready[0]), 32'd1);

        // 4: out of range, no aliasing onto address 0
        txn(0, 1'b1, 32'd0, 32'h0BADC0DE, 4'hF, 0, rd, er, lat);
        txn(0, 1'b1, 32'h2000, 32'h12345678, 4'hF, 0, rd, er, lat);
        chk("t4_err", 32'(er), 32'd1);
        chk("t4_rdata", rd, 32'd0);
        chk("t4_latency", 32'(lat), 32'd3);
        txn(0, 1'b0, 32'd0, 32'd0, 4'h0, 0, rd, er, lat);
        chk("t4_addr0", rd, 32'h0BADC0DE);

        // 5: reset while the store is still waiting
        txn(0, 1'b1, 32'd9, 32'h13579BDF, 4'hF, 0, rd, er, lat);
        @(negedge clock);
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'd9;
        req_wdata[0] = 32'hCAFEF00D; req_wstrb[0] = 4'hF;
        @(negedge clock);
        req_valid[0] = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("t5_valid", 32'(rsp_valid[0]), 32'd0);
        chk("t5_ready", 32'(req_ready[0]), 32'd1);
        chk("t5_rdata", rsp_rdata[0], 32'd0);
        chk("t5_err", 32'(rsp_err[0]), 32'd0);
        txn(0, 1'b0, 32'd9, 32'd0, 4'h0, 0, rd, er, lat);
        chk("t5_load", rd, 32'h13579BDF);

        // 6: latency 0, rsp_ready tied high, back-to-back loads
        txn(1, 1'b1, 32'd3, 32'h33333333, 4'hF, 0, rd, er, lat);
        chk("t6_latency", 32'(lat), 32'd1);
        txn(1, 1'b1, 32'd4, 32'h44444444, 4'hF, 0, rd, er, lat);
        @(negedge clock);
        rsp_ready[1] = 1'b1;
        req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 32'd3;
        nacc = 0;
        c = 0;
        while (nacc < 2 && c < 12) begin
            just = 1'b0;
            if (req_ready[1]) begin
                acc[nacc] = c;
                nacc++;
                just = 1'b1;
            end
            @(negedge clock);
            c++;
            if (just) begin
                chk("t6_valid", 32'(rsp_valid[1]), 32'd1);
                chk("t6_rdata", rsp_rdata[1], (nacc == 1) ? 32'h33333333 : 32'h44444444);
                if (nacc == 1) req_addr[1] = 32'd4;
                else req_valid[1] = 1'b0;
            end
        end
        chk("t6_accepts", 32'(nacc), 32'd2);
        if (nacc == 2) chk("t6_spacing", 32'(acc[1] - acc[0]), 32'd2);
        rsp_ready[1] = 1'b0;
        repeat (3) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0t required=<200000", $time);
        $fatal(1, "timeout");
    end

endmodule
